sysbus_mem_responder: RTL and testbench

Target/responder end of the core's multiplexed 64-bit Sysbus protocol. Decodes nALE/nME/RnW/nOE/ENB strobes from the CPU core, latches the word address and services single-word reads and writes into an internal synchronous memory array. Read data is returned on Data_out, which feeds the core's Data_in. The core gates Data_in onto Sysbus with its own tristate control. Fixed-latency responder: no wait/ready line exists on this bus.

---
 rtl/sysbus_mem_responder.sv | 123 ++++++++++++
 tb/tb_sysbus_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: decodes the multiplexed address/data strobes from the
// core and services single-word reads and writes into an internal word array.
// Fixed latency: read data is registered one edge after nOE is first seen low.
module sysbus_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] Sysbus,
  input  logic                  nALE,
  input  logic                  nME,
  input  logic                  RnW,
  input  logic                  nOE,
  input  logic                  ENB,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  DataValid,
  output logic                  BusError
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRead,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    in_range_q, in_range_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    bus_error_q, bus_error_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  // Next-state, address latch, read data and error decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    in_range_d   = in_range_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    bus_error_d  = bus_error_q;
    mem_we       = 1'b0;

    if (!nALE && !nME) begin
      // Address phase wins over any data action, in any state.
      addr_d       = Sysbus[ADDR_WIDTH-1:0];
      in_range_d   = (Sysbus[DATA_WIDTH-1:ADDR_WIDTH] == '0);
      data_valid_d = 1'b0;
      state_d      = StArmed;
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (nME) begin
            state_d = StIdle;
          end else if (RnW && !nOE) begin
            state_d      = StRead;
            data_valid_d = 1'b1;
            if (in_range_q) begin
              data_out_d = mem_q[addr_q];
            end else begin
              data_out_d  = '0;
              bus_error_d = 1'b1;
            end
          end else if (!RnW && ENB) begin
            state_d = StDone;
            if (in_range_q) begin
              mem_we = 1'b1;
            end else begin
              bus_error_d = 1'b1;
            end
          end
        end
        StRead: begin
          // Data_out keeps its last value; only the valid flag drops.
          if (nOE || nME) data_valid_d = 1'b0;
          if (nME) state_d = StIdle;
        end
        StDone: begin
          // One write per access: further ENB pulses are ignored here.
          if (nME) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      in_range_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      in_range_q   <= in_range_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // Memory array; contents survive reset but no write lands in a reset cycle.
  always_ff @(posedge Clock) begin
    if (nReset && mem_we) begin
      mem_q[addr_q] <= Sysbus;
    end
  end

  assign Data_out  = data_out_q;
  assign DataValid = data_valid_q;
  assign BusError  = bus_error_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder against a word-level memory model.
module tb_sysbus_mem_responder;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [63:0] Sysbus = '0;
  logic        nALE = 1'b1;
  logic        nME = 1'b1;
  logic        RnW = 1'b1;
  logic        nOE = 1'b1;
  logic        ENB = 1'b0;
  logic [63:0] Data_out;
  logic        DataValid;
  logic        BusError;

  int checks = 0;
  int failures = 0;

  // Behavioural model: written words and the sticky error flag.
  logic [63:0] model_mem [int];
  logic        model_err = 1'b0;

  sysbus_mem_responder #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(64)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Sysbus   (Sysbus),
    .nALE     (nALE),
    .nME      (nME),
    .RnW      (RnW),
    .nOE      (nOE),
    .ENB      (ENB),
    .Data_out (Data_out),
    .DataValid(DataValid),
    .BusError (BusError)
  );

  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic bus_idle();
    nALE = 1'b1; nME = 1'b1; RnW = 1'b1; nOE = 1'b1; ENB = 1'b0;
    tick();
  endtask

  task automatic addr_phase(input logic [63:0] a);
    nALE = 1'b0; nME = 1'b0; Sysbus = a;
    tick();
    nALE = 1'b1;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    addr_phase(a);
    RnW = 1'b0; ENB = 1'b1; Sysbus = d;
    tick();
    ENB = 1'b0;
    bus_idle();
    if (a < 64'h400) model_mem[int'(a)] = d;
    else model_err = 1'b1;
  endtask

  // Returns the valid flag seen before nOE takes effect and the result one edge later.
  task automatic do_read(input logic [63:0] a, output logic pre_v,
                         output logic [63:0] d, output logic v);
    addr_phase(a);
    pre_v = DataValid;
    RnW = 1'b1; nOE = 1'b0;
    tick();
    d = Data_out; v = DataValid;
    bus_idle();
    if (a >= 64'h400) model_err = 1'b1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    bus_idle(); tick();
    checks++;
    if (Data_out !== 64'h0 || DataValid !== 1'b0 || BusError !== 1'b0) begin
      failures++;
      $display("FAIL reset: got data=%h v=%b err=%b need 0/0/0", Data_out, DataValid, BusError);
    end
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic pv, v; logic [63:0] d;
    do_write(64'h005, 64'hDEADBEEF_CAFEF00D);
    do_read(64'h005, pv, d, v);
    checks++;
    if (pv !== 1'b0) begin
      failures++; $display("FAIL rd_latency: valid early got %b need 0", pv);
    end
    checks++;
    if (d !== 64'hDEADBEEF_CAFEF00D || v !== 1'b1) begin
      failures++; $display("FAIL wr_rd: got %h v=%b need deadbeefcafef00d v=1", d, v);
    end
    checks++;
    if (BusError !== model_err) begin
      failures++; $display("FAIL wr_rd_err: got %b need %b", BusError, model_err);
    end
  endtask

  task automatic test_single_write();
    logic pv, v; logic [63:0] d;
    addr_phase(64'h010);
    RnW = 1'b0; ENB = 1'b1; Sysbus = 64'h1111; tick();
    ENB = 1'b0; tick();
    ENB = 1'b1; Sysbus = 64'h2222; tick();
    ENB = 1'b0; RnW = 1'b1; tick();
    bus_idle();
    model_mem[16] = 64'h1111;
    do_read(64'h010, pv, d, v);
    checks++;
    if (d !== 64'h1111 || v !== 1'b1) begin
      failures++; $display("FAIL single_write: got %h v=%b need 1111 v=1", d, v);
    end
  endtask

  task automatic test_abort();
    logic pv, v; logic [63:0] d;
    do_write(64'h020, 64'h0123_4567_89AB_CDEF);
    addr_phase(64'h020);
    RnW = 1'b0; Sysbus = 64'h5555; tick();
    nME = 1'b1; tick();
    // Strobes after the abort must be ignored in idle.
    ENB = 1'b1; nOE = 1'b0; RnW = 1'b1; tick();
    checks++;
    if (DataValid !== 1'b0) begin
      failures++; $display("FAIL abort_valid: got %b need 0", DataValid);
    end
    bus_idle();
    do_read(64'h020, pv, d, v);
    checks++;
    if (d !== model_mem[32]) begin
      failures++; $display("FAIL abort_mem: got %h need %h", d, model_mem[32]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a_val, b_val;
    a_val = {$urandom, $urandom}; b_val = {$urandom, $urandom};
    do_write(64'h001, a_val);
    do_write(64'h002, b_val);
    addr_phase(64'h001);
    RnW = 1'b1; nOE = 1'b0; tick();
    checks++;
    if (Data_out !== a_val || DataValid !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got %h v=%b need %h v=1", Data_out, DataValid, a_val);
    end
    nALE = 1'b0; Sysbus = 64'h002; tick();
    nALE = 1'b1;
    checks++;
    if (DataValid !== 1'b0) begin
      failures++; $display("FAIL b2b_drop: got %b need 0", DataValid);
    end
    tick();
    checks++;
    if (Data_out !== b_val || DataValid !== 1'b1) begin
      failures++; $display("FAIL b2b_second: got %h v=%b need %h v=1", Data_out, DataValid, b_val);
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic pv, v; logic [63:0] d; logic [63:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 64'($urandom_range(0, 63)) + 64'h40;
      if ($urandom_range(0, 1) == 0 || !model_mem.exists(int'(a))) begin
        do_write(a, {$urandom, $urandom});
      end else begin
        do_read(a, pv, d, v);
        checks++;
        if (d !== model_mem[int'(a)] || v !== 1'b1) begin
          failures++;
          $display("FAIL random_rd[%0d]: addr %h got %h v=%b need %h v=1",
                   i, a, d, v, model_mem[int'(a)]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic pv, v; logic [63:0] d;
    do_write(64'h000, 64'hA5A5_0000_5A5A_FFFF);
    do_write(64'h400, 64'hFF);
    checks++;
    if (BusError !== 1'b1) begin
      failures++; $display("FAIL oor_wr_err: got %b need 1", BusError);
    end
    do_read(64'h400, pv, d, v);
    checks++;
    if (d !== 64'h0 || v !== 1'b1) begin
      failures++; $display("FAIL oor_rd: got %h v=%b need 0 v=1", d, v);
    end
    do_read(64'h000, pv, d, v);
    checks++;
    if (d !== model_mem[0]) begin
      failures++; $display("FAIL oor_word0: got %h need %h", d, model_mem[0]);
    end
    repeat (3) tick();
    checks++;
    if (BusError !== model_err) begin
      failures++; $display("FAIL oor_sticky: got %b need %b", BusError, model_err);
    end
  endtask

  task automatic test_reset_mid_read();
    logic pv, v; logic [63:0] d;
    addr_phase(64'h005);
    RnW = 1'b1; nOE = 1'b0; tick();
    checks++;
    if (DataValid !== 1'b1) begin
      failures++; $display("FAIL rst_pre: got %b need 1", DataValid);
    end
    nReset = 1'b0; tick();
    model_err = 1'b0;
    checks++;
    if (Data_out !== 64'h0 || DataValid !== 1'b0 || BusError !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got data=%h v=%b err=%b need 0/0/0", Data_out, DataValid, BusError);
    end
    // Strobes still asserted but no address phase: must stay idle.
    nReset = 1'b1; tick();
    checks++;
    if (DataValid !== 1'b0) begin
      failures++; $display("FAIL rst_idle: got %b need 0", DataValid);
    end
    bus_idle();
    foreach (model_mem[k]) begin
      do_read(64'(k), pv, d, v);
      checks++;
      if (d !== model_mem[k] || v !== 1'b1) begin
        failures++; $display("FAIL rst_keep[%0h]: got %h need %h", k, d, model_mem[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_single_write();
    test_abort();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
